// File: rtl/plot_framebuffer_vga_pkg.sv
// plot_framebuffer_vga_pkg: shared VGA timing, framebuffer geometry and output bundle types
package plot_framebuffer_vga_pkg;
    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_BP   = 10'd48;
    localparam logic [9:0] H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_BP   = 10'd33;
    localparam logic [9:0] V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [7:0] FB_W   = 8'd160;
    localparam logic [6:0] FB_H   = 7'd120;
    localparam int FB_DEPTH = 160 * 120;
    localparam int COL_W    = 3;
    localparam int SCALE_SH = 2;

    typedef struct packed {
        logic [COL_W-1:0] rgb;
        logic             hs;
        logic             vs;
        logic             blank_n;
    } vga_out_t;

    localparam vga_out_t OUT_RST = '{rgb: '0, hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    // y*160 + x as y*128 + y*32 + x, kept to 15 bits
    function automatic logic [14:0] fb_addr(input logic [6:0] fy, input logic [7:0] fx);
        return 15'({fy, 7'b0}) + 15'({fy, 5'b0}) + 15'(fx);
    endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 pixel tick, scan counters, raw sync/visible flags
module vga_timing_gen
    import plot_framebuffer_vga_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    output logic       pix_en_o,
    output logic [7:0] col_o,
    output logic [6:0] row_o,
    output logic       hs_raw_o,
    output logic       vs_raw_o,
    output logic       vis_o
);
    logic       pix_en_q, pix_en_d, h_wrap;
    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

    // tick toggles every clk; counters step only on tick cycles
    always_comb begin
        pix_en_d = !pix_en_q;
        h_wrap   = h_cnt_q == H_TOT - 10'd1;
        h_cnt_d  = pix_en_q ? (h_wrap ? '0 : h_cnt_q + 10'd1) : h_cnt_q;
        v_cnt_d  = (pix_en_q && h_wrap) ? (v_cnt_q == V_TOT - 10'd1 ? '0 : v_cnt_q + 10'd1) : v_cnt_q;
    end

    // scan state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_en_q <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
        end else begin
            pix_en_q <= pix_en_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
        end
    end

    assign pix_en_o = pix_en_q;
    assign col_o    = h_cnt_q[9:SCALE_SH];
    assign row_o    = v_cnt_q[8:SCALE_SH];
    assign hs_raw_o = !(h_cnt_q >= H_VIS + H_FP && h_cnt_q < H_VIS + H_FP + H_SYNC);
    assign vs_raw_o = !(v_cnt_q >= V_VIS + V_FP && v_cnt_q < V_VIS + V_FP + V_SYNC);
    assign vis_o    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
endmodule

// File: rtl/plot_framebuffer_vga.sv
// plot_framebuffer_vga: 160x120x3 plot framebuffer scanned out to 640x480 VGA with 4x4 replication
module plot_framebuffer_vga
    import plot_framebuffer_vga_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);
    logic             pix_en, hs_raw, vs_raw, vis, we, vclk_q;
    logic [7:0]       col;
    logic [6:0]       row;
    logic [14:0]      wr_addr, rd_addr;
    logic [COL_W-1:0] mem_q [FB_DEPTH];
    logic [COL_W-1:0] rd_q;
    vga_out_t         out_q, out_d;

    vga_timing_gen u_timing (
        .clk      (clk),
        .resetn   (resetn),
        .pix_en_o (pix_en),
        .col_o    (col),
        .row_o    (row),
        .hs_raw_o (hs_raw),
        .vs_raw_o (vs_raw),
        .vis_o    (vis)
    );

    assign we      = plot && (x < FB_W) && (y < FB_H);
    assign wr_addr = fb_addr(y, x);
    assign rd_addr = vis ? fb_addr(row, col) : '0;

    // framebuffer RAM, not reset; a read colliding with a write sees the old colour
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr] <= colour;
        rd_q <= mem_q[rd_addr];
    end

    // on each tick capture pixel data and the sync/blank flags of the same scan position
    always_comb begin
        out_d = pix_en ? '{rgb: vis ? rd_q : '0, hs: hs_raw, vs: vs_raw, blank_n: vis} : out_q;
    end

    // aligned output registers and pixel clock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q  <= OUT_RST;
            vclk_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            vclk_q <= pix_en;
        end
    end

    assign VGA_R       = {8{out_q.rgb[2]}};
    assign VGA_G       = {8{out_q.rgb[1]}};
    assign VGA_B       = {8{out_q.rgb[0]}};
    assign VGA_HS      = out_q.hs;
    assign VGA_VS      = out_q.vs;
    assign VGA_BLANK_N = out_q.blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vclk_q;
endmodule
